// File: rtl/palindrome_checker_seq_if.sv
// ---------------------------------------------------------------------------
// palindrome_checker_seq_if
// Handshake/result bundle for palindrome_checker_seq.
//   start         : request, sampled only while the checker is idle
//   mode          : 0 = decimal digits, 1 = binary bits (latched with number)
//   number        : WIDTH-bit unsigned operand (latched on acceptance)
//   busy          : checker is working on an accepted request
//   done          : one-cycle pulse, results valid
//   is_palindrome : registered result flag
//   length        : significant digit/bit count (0 reports 1)
// master = requester side, slave = checker side.
// ---------------------------------------------------------------------------
interface palindrome_checker_seq_if #(
  parameter int WIDTH = 10
);
  localparam int LW = $clog2(WIDTH + 1);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] number;
  logic             busy;
  logic             done;
  logic             is_palindrome;
  logic [LW-1:0]    length;

  modport master (
    output start, mode, number,
    input  busy, done, is_palindrome, length
  );

  modport slave (
    input  start, mode, number,
    output busy, done, is_palindrome, length
  );
endinterface

// File: rtl/palindrome_checker_seq.sv
// ---------------------------------------------------------------------------
// palindrome_checker_seq
// Sequential palindrome check of a WIDTH-bit unsigned number. In decimal mode
// the number is converted to BCD serially (shift-add-3, one bit per cycle,
// MSB first), then significant digits are compared pairwise, one pair per
// cycle. In binary mode the significant bits are compared pairwise directly.
// Leading zeros are never part of the comparison.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of palindrome_checker_seq_if (start/mode/number in,
//          busy/done/is_palindrome/length out, all outputs registered)
// ---------------------------------------------------------------------------
module palindrome_checker_seq #(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  palindrome_checker_seq_if.slave bus
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_LENGTH  = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  // One double-dabble step: correct every nibble >= 5, then shift in one bit.
  function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] bcd, input logic in_bit);
    logic [BW-1:0] adj;
    adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (adj[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end else begin
        adj[4*k +: 4] = adj[4*k +: 4];
      end
    end
    return {adj[BW-2:0], in_bit};
  endfunction

  // Index of the highest nonzero digit/set bit plus one; a zero value gives 1.
  function automatic logic [LW-1:0] sig_len(input logic m, input logic [BW-1:0] bcd,
                                            input logic [WIDTH-1:0] v);
    logic [LW-1:0] l;
    l = LW'(1);
    if (m) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (v[k]) l = LW'(k + 1);
        else      l = l;
      end
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (bcd[4*k +: 4] != 4'd0) l = LW'(k + 1);
        else                       l = l;
      end
    end
    return l;
  endfunction

  // Element idx of the operand: a BCD digit, or a single bit zero-extended.
  function automatic logic [3:0] elem(input logic m, input logic [BW-1:0] bcd,
                                      input logic [WIDTH-1:0] v, input logic [LW-1:0] idx);
    logic [3:0] e;
    e = 4'd0;
    if (m) begin
      for (int k = 0; k < WIDTH; k++) begin
        if (LW'(k) == idx) e = {3'b000, v[k]};
        else               e = e;
      end
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (LW'(k) == idx) e = bcd[4*k +: 4];
        else               e = e;
      end
    end
    return e;
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;   // operand; shifted out during CONVERT
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             mode_q, mode_d;
  logic [LW-1:0]    cnt_q, cnt_d;       // conversion bit count, then pair index
  logic [LW-1:0]    l_q, l_d;           // significant length of current run
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pal_q, pal_d;
  logic [LW-1:0]    length_q, length_d;

  logic [LW-1:0]    len_s;
  logic [LW-1:0]    hi_idx_s;
  logic [LW-1:0]    half_m1_s;
  logic [3:0]       elem_lo_s;
  logic [3:0]       elem_hi_s;
  logic             load_s;
  logic             res_s;

  assign len_s     = sig_len(mode_q, bcd_q, shift_q);
  assign hi_idx_s  = l_q - LW'(1) - cnt_q;
  assign half_m1_s = (l_q >> 1) - LW'(1);
  assign elem_lo_s = elem(mode_q, bcd_q, shift_q, cnt_q);
  assign elem_hi_s = elem(mode_q, bcd_q, shift_q, hi_idx_s);

  // Next-state, datapath and result-load logic.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    load_s  = 1'b0;
    res_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = bus.number;
          mode_d  = bus.mode;
          bcd_d   = {BW{1'b0}};
          cnt_d   = {LW{1'b0}};
          state_d = bus.mode ? S_LENGTH : S_CONVERT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        bcd_d   = dd_step(bcd_q, shift_q[WIDTH-1]);
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + LW'(1);
        if (cnt_q == LW'(WIDTH - 1)) begin
          state_d = S_LENGTH;
        end else begin
          state_d = S_CONVERT;
        end
      end
      S_LENGTH: begin
        l_d   = len_s;
        cnt_d = {LW{1'b0}};
        if (len_s == LW'(1)) begin
          load_s  = 1'b1;
          res_s   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (elem_lo_s != elem_hi_s) begin
          load_s  = 1'b1;
          res_s   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == half_m1_s) begin
          load_s  = 1'b1;
          res_s   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + LW'(1);
          state_d = S_COMPARE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d   = (state_d == S_CONVERT) || (state_d == S_LENGTH) || (state_d == S_COMPARE);
    done_d   = (state_d == S_DONE);
    pal_d    = load_s ? res_s : pal_q;
    length_d = load_s ? l_d : length_q;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= {WIDTH{1'b0}};
      bcd_q    <= {BW{1'b0}};
      mode_q   <= 1'b0;
      cnt_q    <= {LW{1'b0}};
      l_q      <= {LW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pal_q    <= 1'b0;
      length_q <= {LW{1'b0}};
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bcd_q    <= bcd_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pal_q    <= pal_d;
      length_q <= length_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.is_palindrome = pal_q;
  assign bus.length        = length_q;
endmodule
